// File: rtl/dpram_rd_streamer_if.sv
// dpram_rd_streamer_if: command, RAM port B and output stream bundle; STREAMER_STRIDE_EN adds cmd_stride
interface dpram_rd_streamer_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0] cmd_len;
`ifdef STREAMER_STRIDE_EN
  logic [AW-1:0] cmd_stride;
`endif
  logic ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;
  logic m_valid, m_ready, m_last, done, busy;
  logic [DW-1:0] m_data;
`ifdef STREAMER_STRIDE_EN
  modport master (output cmd_valid, cmd_base, cmd_len, cmd_stride, ram_dob, m_ready,
                  input cmd_ready, ram_enb, ram_addrb, m_valid, m_data, m_last, done, busy);
  modport slave (input cmd_valid, cmd_base, cmd_len, cmd_stride, ram_dob, m_ready,
                 output cmd_ready, ram_enb, ram_addrb, m_valid, m_data, m_last, done, busy);
`else
  modport master (output cmd_valid, cmd_base, cmd_len, ram_dob, m_ready,
                  input cmd_ready, ram_enb, ram_addrb, m_valid, m_data, m_last, done, busy);
  modport slave (input cmd_valid, cmd_base, cmd_len, ram_dob, m_ready,
                 output cmd_ready, ram_enb, ram_addrb, m_valid, m_data, m_last, done, busy);
`endif
endinterface

// File: rtl/dpram_rd_streamer.sv
// dpram_rd_streamer: burst reader for RAM port B with read-latency tracking and a skid FIFO; STREAMER_STRIDE_EN adds a per-command stride
module dpram_rd_streamer #(
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int N_DELAY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dpram_rd_streamer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] cur_addr, last_addr, stride;
  logic [AW:0] len, issued;
  logic [N_DELAY-1:0] tok_vld, tok_last;
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count, inflight;
  logic zero_done, accept, issue, last_issue, enb, push, pop;

  assign push = tok_vld[N_DELAY-1];
  assign pop = count != '0 && bus.m_ready;
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.ram_enb = enb;
  assign bus.ram_addrb = issue ? cur_addr : last_addr;
  assign bus.m_valid = count != '0;
  assign bus.m_data = fifo_data[rp];
  assign bus.m_last = count != '0 && fifo_last[rp];
  assign bus.done = zero_done || (pop && fifo_last[rp]);

`ifdef STREAMER_STRIDE_EN
  // stride is captured with the command
  always_ff @(posedge clk) if (state == IDLE && bus.cmd_valid) stride <= bus.cmd_stride;
`else
  assign stride = AW'(1);
`endif

  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  // next state, credit-checked issue and RAM enable (held while any token is in flight)
  always_comb begin
    state_n = state;
    inflight = CW'($countones(tok_vld));
    last_issue = issued + (AW+1)'(1) == len;
    accept = state == IDLE && bus.cmd_valid;
    issue = state == RUN && inflight + count < CW'(FIFO_DEPTH);
    enb = issue || (state != IDLE && |tok_vld);
    if (accept) state_n = bus.cmd_len == '0 ? IDLE : RUN;
    if (issue && last_issue) state_n = DRAIN;
    if (state == DRAIN && pop && fifo_last[rp]) state_n = IDLE;
  end

  // command latch, address generation, token pipeline and skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      issued <= '0;
      last_addr <= '0;
      tok_vld <= '0;
      zero_done <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      zero_done <= accept && bus.cmd_len == '0;
      if (accept) begin
        cur_addr <= bus.cmd_base;
        len <= bus.cmd_len;
        issued <= '0;
      end
      if (issue) begin
        cur_addr <= cur_addr + stride;
        last_addr <= cur_addr;
        issued <= issued + (AW+1)'(1);
      end
      if (enb) begin
        tok_vld[0] <= issue;
        tok_last[0] <= last_issue;
        for (int i = 1; i < N_DELAY; i++) begin
          tok_vld[i] <= tok_vld[i-1];
          tok_last[i] <= tok_last[i-1];
        end
      end
      if (push) begin
        fifo_data[wp] <= bus.ram_dob;
        fifo_last[wp] <= tok_last[N_DELAY-1];
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // a returning word must never meet a full FIFO
  always_ff @(posedge clk) if (!rst && push) assert (count < CW'(FIFO_DEPTH));
endmodule
